// File: rtl/down_counter_timer.sv
// Loadable down counter / interval timer with start/stop, count enable,
// optional auto-reload and a one-cycle terminal-count pulse.
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_en,
    input  logic             i_auto_reload,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_state
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_busy;
    logic             r_done;
    logic             w_load_zero;

    assign w_load_zero = (i_load_val == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start && !i_stop) begin
                        r_reload <= i_load_val;
                        r_count  <= i_load_val;
                        if (w_load_zero) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_stop) begin
                        r_state <= ST_IDLE;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else if (i_start) begin
                        r_reload <= i_load_val;
                        r_count  <= i_load_val;
                        if (w_load_zero) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_done  <= 1'b0;
                        end
                    end else if (!i_en) begin
                        r_done <= 1'b0;
                    end else if (r_count > WIDTH'(1)) begin
                        r_count <= r_count - WIDTH'(1);
                        r_done  <= 1'b0;
                    end else if (r_count == WIDTH'(1)) begin
                        // auto_reload is only looked at on this terminal edge
                        r_count <= '0;
                        r_done  <= 1'b1;
                        if (!i_auto_reload) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_count <= r_reload;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_count = r_count;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_state = r_state;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed, table-driven bench for down_counter_timer (WIDTH=4) with a
// few hand-written multi-cycle sequences.
module tb_down_counter_timer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         stop;
    logic         en;
    logic         auto_reload;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         rst;
        logic         start;
        logic         stop;
        logic         en;
        logic         ar;
        logic [W-1:0] ld;
        logic [W-1:0] exp_count;
        logic         exp_busy;
        logic         exp_done;
    } vec_t;

    vec_t vecs[$];

    down_counter_timer #(.WIDTH(W)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_stop        (stop),
        .i_en          (en),
        .i_auto_reload (auto_reload),
        .i_load_val    (load_val),
        .o_count       (count),
        .o_busy        (busy),
        .o_done        (done),
        .o_state       (state)
    );

    always #5 clk = ~clk;

    task automatic add_vec(input logic r, input logic s, input logic p, input logic e,
                           input logic a, input logic [W-1:0] l,
                           input logic [W-1:0] c, input logic b, input logic d);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p; v.en = e; v.ar = a; v.ld = l;
        v.exp_count = c; v.exp_busy = b; v.exp_done = d;
        vecs.push_back(v);
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic s, input logic p, input logic e,
                        input logic a, input logic [W-1:0] l);
        @(negedge clk);
        rst = r; start = s; stop = p; en = e; auto_reload = a; load_val = l;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx,
                         input logic [W-1:0] c, input logic b, input logic d);
        checks++;
        if (count !== c || busy !== b || done !== d) begin
            errors++;
            $display("FAIL %s[%0d]: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
                     name, idx, count, busy, done, c, b, d);
        end
    endtask

    initial begin
        int done_cnt;
        int prev_done;
        rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0; auto_reload = 1'b0; load_val = '0;

        // rst r, start s, stop p, en e, auto_reload a, load_val l -> count, busy, done
        // reset held with start asserted, then quiet IDLE
        add_vec(1,1,0,0,0,9,  0,0,0);
        add_vec(1,1,0,0,0,9,  0,0,0);
        add_vec(0,0,0,1,0,9,  0,0,0);
        add_vec(0,0,0,0,0,0,  0,0,0);
        // one-shot from 5
        add_vec(0,1,0,1,0,5,  5,1,0);
        add_vec(0,0,0,1,0,0,  4,1,0);
        add_vec(0,0,0,1,0,0,  3,1,0);
        add_vec(0,0,0,1,0,0,  2,1,0);
        add_vec(0,0,0,1,0,0,  1,1,0);
        add_vec(0,0,0,1,0,0,  0,0,1);
        add_vec(0,0,0,1,0,0,  0,0,0);
        // auto-reload from 3: period of four enabled cycles
        add_vec(0,1,0,1,1,3,  3,1,0);
        add_vec(0,0,0,1,1,0,  2,1,0);
        add_vec(0,0,0,1,1,0,  1,1,0);
        add_vec(0,0,0,1,1,0,  0,1,1);
        add_vec(0,0,0,1,1,0,  3,1,0);
        add_vec(0,0,0,1,1,0,  2,1,0);
        add_vec(0,0,0,1,1,0,  1,1,0);
        add_vec(0,0,0,1,1,0,  0,1,1);
        add_vec(0,0,1,1,1,0,  0,0,0);
        // enable gating from 4
        add_vec(0,1,0,0,0,4,  4,1,0);
        add_vec(0,0,0,1,0,0,  3,1,0);
        add_vec(0,0,0,0,0,0,  3,1,0);
        add_vec(0,0,0,1,0,0,  2,1,0);
        add_vec(0,0,0,0,0,0,  2,1,0);
        add_vec(0,0,0,1,0,0,  1,1,0);
        add_vec(0,0,0,0,0,0,  1,1,0);
        add_vec(0,0,0,1,0,0,  0,0,1);
        // stop at count 6
        add_vec(0,1,0,1,0,9,  9,1,0);
        add_vec(0,0,0,1,0,0,  8,1,0);
        add_vec(0,0,0,1,0,0,  7,1,0);
        add_vec(0,0,0,1,0,0,  6,1,0);
        add_vec(0,0,1,1,0,0,  0,0,0);
        // start+stop in RUN and in IDLE: stop wins
        add_vec(0,1,0,1,0,8,  8,1,0);
        add_vec(0,1,1,1,0,5,  0,0,0);
        add_vec(0,1,1,1,0,5,  0,0,0);
        // restart during RUN with 2
        add_vec(0,1,0,1,0,8,  8,1,0);
        add_vec(0,0,0,1,0,0,  7,1,0);
        add_vec(0,1,0,1,0,2,  2,1,0);
        add_vec(0,0,0,1,0,0,  1,1,0);
        add_vec(0,0,0,1,0,0,  0,0,1);
        // restart during RUN with 0 -> IDLE plus done
        add_vec(0,1,0,1,0,5,  5,1,0);
        add_vec(0,1,0,1,0,0,  0,0,1);
        add_vec(0,0,0,1,0,0,  0,0,0);
        // start with 0 from IDLE
        add_vec(0,1,0,0,0,0,  0,0,1);
        add_vec(0,0,0,0,0,0,  0,0,0);
        // rst at count 7
        add_vec(0,1,0,1,0,9,  9,1,0);
        add_vec(0,0,0,1,0,0,  8,1,0);
        add_vec(0,0,0,1,0,0,  7,1,0);
        add_vec(1,0,0,1,0,0,  0,0,0);
        add_vec(0,0,0,1,0,0,  0,0,0);
        // auto_reload sampled only at the count==1 edge
        add_vec(0,1,0,1,1,2,  2,1,0);
        add_vec(0,0,0,1,0,0,  1,1,0);
        add_vec(0,0,0,1,1,0,  0,1,1);
        add_vec(0,0,0,1,0,0,  2,1,0);
        add_vec(0,0,0,1,0,0,  1,1,0);
        add_vec(0,0,0,1,0,0,  0,0,1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].en, vecs[i].ar, vecs[i].ld);
            check("vec", i, vecs[i].exp_count, vecs[i].exp_busy, vecs[i].exp_done);
        end

        // full-range countdown from 15, no wrap after reaching zero
        step(0,1,0,1,0,15);
        check("max_load", 15, 15, 1, 0);
        for (int n = 14; n >= 0; n--) begin
            step(0,0,0,1,0,0);
            check("max_load", n, W'(n), (n != 0), (n == 0));
        end
        for (int k = 0; k < 3; k++) begin
            step(0,0,0,1,0,0);
            check("no_wrap", k, 0, 0, 0);
        end

        // auto-reload over 12 enabled cycles from 3: three single-cycle done pulses
        step(0,1,0,1,1,3);
        done_cnt  = 0;
        prev_done = 0;
        for (int k = 0; k < 12; k++) begin
            step(0,0,0,1,1,0);
            if (done === 1'b1) done_cnt++;
            checks++;
            if (done === 1'b1 && prev_done == 1) begin
                errors++;
                $display("FAIL ar_double_done[%0d]: got done high twice in a row, want single pulse", k);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL ar_busy[%0d]: got busy=%0b, want 1", k, busy);
            end
            prev_done = (done === 1'b1) ? 1 : 0;
        end
        checks++;
        if (done_cnt != 3) begin
            errors++;
            $display("FAIL ar_pulses: got %0d done pulses, want 3", done_cnt);
        end
        step(0,0,1,0,0,0);
        check("ar_stop", 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
